fetch_sequencer: RTL and testbench

Control block for the instruction-fetch stage. It sequences the program counter register, the instruction-memory request and the IF/ID pipeline buffer. It arbitrates between sequential advance (PC + INST_BYTES), taken branches, jumps, pipeline stalls and a variable-latency instruction memory. It drives the PC data input and the PC and IF/ID enables, and detects memory timeouts.

---
 rtl/fetch_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: sequences PC updates, imem requests and the IF/ID buffer.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_sequencer #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 32'h0000_0000,
  parameter int unsigned        INST_BYTES = 4,
  parameter int unsigned        MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic [2:0]        fetch_state,
  output logic              timeout_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalls,
  output logic [31:0]       perf_redirects
`endif
);

  localparam int unsigned       CntW      = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(INST_BYTES - 1);

  typedef enum logic [2:0] {
    StBoot     = 3'd0,
    StFetch    = 3'd1,
    StWait     = 3'd2,
    StRedirect = 3'd3,
    StFault    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic              timeout_q, timeout_d;

  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign redir     = jump | branch_taken;
  assign redir_tgt = (jump ? jump_target : branch_target) & AlignMask;
  assign pc_inc    = pc_q + ADDR_W'(INST_BYTES);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    timeout_d  = timeout_q;
    imem_req   = 1'b0;
    pc_we      = 1'b0;
    pc_next    = pc_inc;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;

    case (state_q)
      StBoot: begin
        pc_we      = 1'b1;
        pc_next    = RESET_PC;
        ifid_flush = 1'b1;
        state_d    = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redir) begin
          pc_we      = 1'b1;
          pc_next    = redir_tgt;
          ifid_flush = 1'b1;
          state_d    = StRedirect;
        end else if (stall) begin
          state_d = StFetch;
        end else if (imem_ready) begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end else begin
          state_d    = StWait;
          wait_cnt_d = CntW'(1);
        end
      end
      StWait: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          wait_cnt_d = '0;
          pend_d     = 1'b0;
          state_d    = StFetch;
          // A redirect arriving together with ready is treated as already pending.
          if (redir || pend_q) begin
            pc_we      = 1'b1;
            pc_next    = redir ? redir_tgt : pend_tgt_q;
            ifid_flush = 1'b1;
            state_d    = StRedirect;
          end else if (!stall) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end else if (wait_cnt_q == CntW'(MAX_WAIT)) begin
          timeout_d  = 1'b1;
          wait_cnt_d = '0;
          pend_d     = 1'b0;
          state_d    = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
          if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end
        end
      end
      StRedirect: begin
        ifid_flush = 1'b1;
        state_d    = StFetch;
      end
      StFault: begin
        ifid_flush = 1'b1;
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = StBoot;
      end
    endcase

    // Outputs are held safe while reset is asserted.
    if (!rst_n) begin
      imem_req   = 1'b0;
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      pc_next    = RESET_PC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      wait_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign fetch_state = state_q;
  assign timeout_err = timeout_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stalls_q, perf_redirects_q;
  logic        stall_evt;

  assign stall_evt = ((state_q == StFetch) && stall) || (state_q == StWait);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_stalls_q    <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (ifid_we && (perf_fetched_q != '1)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (stall_evt && (perf_stalls_q != '1)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
      if ((state_d == StRedirect) && (perf_redirects_q != '1)) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_stalls    = perf_stalls_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_fetch_sequencer;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned MAX_WAIT   = 15;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_q;
  logic        stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, pc_we, ifid_we, ifid_flush, timeout_err;
  logic [31:0] pc_next;
  logic [2:0]  fetch_state;

  fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (RESET_PC),
    .INST_BYTES (INST_BYTES),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_q          (pc_q),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc_we         (pc_we),
    .pc_next       (pc_next),
    .ifid_we       (ifid_we),
    .ifid_flush    (ifid_flush),
    .fetch_state   (fetch_state),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic        ifwe;
    logic        flush;
    logic [31:0] next;
    logic        chk_next;
    logic [2:0]  st;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: phase flags rather than a state register.
  bit          m_boot, m_bubble, m_fault, m_pend;
  int          m_wait;           // cycles spent waiting, 0 = not waiting
  logic [31:0] m_pend_tgt;
  logic [31:0] pc_reg;           // the PC register the bench owns
  bit          last_we;
  logic [31:0] last_next;
  bit          force_pc;
  logic [31:0] force_val;

  function automatic logic [31:0] align(input logic [31:0] a);
    return (a / INST_BYTES) * INST_BYTES;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_bubble = 0; m_fault = 0; m_pend = 0; m_wait = 0; m_pend_tgt = '0;
  endtask

  task automatic cycle(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit rdy);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    if (last_we) pc_reg = last_next;
    if (force_pc) begin
      pc_reg   = force_val;
      force_pc = 0;
    end
    rst_n = rst; stall = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; imem_ready = rdy; pc_q = pc_reg;

    redir = j || br;
    tgt   = align(j ? jt : bt);
    e.req = 0; e.we = 0; e.ifwe = 0; e.flush = 0; e.chk_next = 0;
    e.next = pc_reg + INST_BYTES;
    e.to   = m_fault;
    e.st   = m_fault ? 3'd4 : m_boot ? 3'd0 : m_bubble ? 3'd3 : (m_wait > 0) ? 3'd2 : 3'd1;

    if (!rst) begin
      model_reset();
      e.flush = 1; e.next = RESET_PC; e.chk_next = 1; e.st = 3'd0; e.to = 0;
    end else if (m_fault) begin
      e.flush = 1;
    end else if (m_boot) begin
      e.we = 1; e.next = RESET_PC; e.flush = 1; m_boot = 0;
    end else if (m_bubble) begin
      e.flush = 1; m_bubble = 0;
    end else if (m_wait > 0) begin
      e.req = 1;
      if (rdy) begin
        if (redir || m_pend) begin
          e.we = 1; e.flush = 1; e.next = redir ? tgt : m_pend_tgt; m_bubble = 1;
        end else if (!st) begin
          e.we = 1; e.ifwe = 1;
        end
        m_wait = 0; m_pend = 0;
      end else if (m_wait == MAX_WAIT) begin
        m_fault = 1; m_wait = 0; m_pend = 0;
      end else begin
        m_wait++;
        if (redir) begin
          m_pend = 1; m_pend_tgt = tgt;
        end
      end
    end else begin
      e.req = 1;
      if (redir) begin
        e.we = 1; e.next = tgt; e.flush = 1; m_bubble = 1;
      end else if (st) begin
        e.we = 0;
      end else if (rdy) begin
        e.we = 1; e.ifwe = 1;
      end else begin
        m_wait = 1;
      end
    end
    last_we   = e.we;
    last_next = e.next;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, want);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("imem_req",    32'(imem_req),    32'(mon_e.req));
      chk("pc_we",       32'(pc_we),       32'(mon_e.we));
      chk("ifid_we",     32'(ifid_we),     32'(mon_e.ifwe));
      chk("ifid_flush",  32'(ifid_flush),  32'(mon_e.flush));
      chk("fetch_state", 32'(fetch_state), 32'(mon_e.st));
      chk("timeout_err", 32'(timeout_err), 32'(mon_e.to));
      if (mon_e.we || mon_e.chk_next) chk("pc_next", pc_next, mon_e.next);
    end
  end

  task automatic run_ready(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, '0, 0, '0, 1);
  endtask

  initial begin
    rst_n = 0; stall = 0; branch_taken = 0; jump = 0; imem_ready = 0;
    branch_target = '0; jump_target = '0; pc_q = '0;
    model_reset();
    pc_reg = '0; last_we = 0; last_next = '0; force_pc = 0; force_val = '0;

    // Reset, boot and sequential fetch 0 -> 4 -> 8
    cycle(0, 0, 0, '0, 0, '0, 1);
    cycle(0, 0, 0, '0, 0, '0, 1);
    run_ready(3);
    // Taken branch at pc 0x8 to 0x40, bubble, fetch at 0x40
    cycle(1, 0, 1, 32'h40, 0, '0, 1);
    run_ready(2);
    // Stall three cycles at 0x10, then advance
    force_pc = 1; force_val = 32'h10;
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, '0, 0, '0, 1);
    run_ready(1);
    // Two wait cycles with a jump latched mid-wait; redirect on ready
    cycle(1, 0, 0, '0, 0, '0, 0);
    cycle(1, 0, 0, '0, 1, 32'h100, 0);
    cycle(1, 0, 0, '0, 0, '0, 1);
    run_ready(2);
    // Memory never ready: timeout into fault, then reset clears it
    for (int i = 0; i < MAX_WAIT + 4; i++) cycle(1, 0, 0, '0, 0, '0, 0);
    cycle(0, 0, 0, '0, 0, '0, 0);
    run_ready(2);
    // Wrap-around and target alignment
    force_pc = 1; force_val = 32'hFFFF_FFFC;
    run_ready(1);
    cycle(1, 0, 1, 32'h43, 0, '0, 1);
    run_ready(2);
    // Reset dropped in the middle of a wait with a pending redirect
    cycle(1, 0, 0, '0, 0, '0, 0);
    cycle(1, 0, 1, 32'h200, 0, '0, 0);
    cycle(0, 0, 0, '0, 0, '0, 1);
    run_ready(3);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 8), $urandom(),
            ($urandom_range(0, 99) < 5), $urandom(),
            ($urandom_range(0, 9) < 6));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got=%0d entries left, expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
